iterative_alu: RTL
==================

Name: iterative_alu

Overview:
- Parametrised successor to the datapath ALU. Operand width is set by WIDTH, and the block adds multi-cycle unsigned multiply and divide.
- It accepts one operation per Start pulse, registers both the result and the ZCNO flag register, and reports completion with a one-cycle Done pulse.
- It sits beside the register file and is driven by the control unit. Both multi-cycle ops run iteratively, one bit per cycle.

Parameters:
- WIDTH, default 32: operand/result width. Must be even and at least 4.
- CNT_W, default $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

Ports:
- Clock, input, 1: rising-edge clock.
- Reset, input, 1: synchronous, active-high reset.
- Start, input, 1: request. Accepted only in IDLE or FIN.
- Op, input, 5: operation select.
- A, input, WIDTH: operand A.
- B, input, WIDTH: operand B.
- WF, input, 1: write-flags enable. Sampled with Start.
- Busy, output, 1: high while in RUN.
- Done, output, 1: high for exactly one cycle, in FIN.
- ALUOut, output, WIDTH: result. For MULU, low product. For DIVU, quotient.
- ALUOutHi, output, WIDTH: MULU high product; DIVU remainder; 0 for all other ops.
- FlagsOut, output, 4: {Z,C,N,O}, MSB to LSB.
- DivByZero, output, 1: set on DIVU with B==0. Cleared on the next accepted Start.

Behaviour:
- Reset: when Reset=1 at a rising edge:
  - state goes to IDLE;
  - Busy, Done, ALUOut, ALUOutHi, FlagsOut, DivByZero all go to 0.
  - Reset wins over Start. Reset during RUN aborts the op with no Done and no flag update.
- States: IDLE, RUN, FIN.
  - IDLE/FIN + Start, single-cycle op -> FIN.
  - IDLE/FIN + Start, MULU/DIVU (B!=0) -> RUN.
  - RUN, counter reaches WIDTH -> FIN.
  - FIN without Start -> IDLE.
- Start in RUN is ignored: no queueing, no effect.
- On accept, latch A, B, Op, WF and the current C flag (C0).
- Latency: single-cycle ops assert Done on the cycle after Start. MULU and DIVU assert Done WIDTH+1 cycles after Start.
- Results and flags are written on the edge entering FIN. They hold until the next op completes.
- Back-to-back: Start during FIN is accepted. Done drops the following cycle unless that op is also single-cycle, in which case FIN repeats with Done high.
- Ops (0x = hex):
  - 00 A; 01 B; 02 ~A; 03 ~B.
  - 04 A+B; 05 A+B+C0; 06 A-B.
  - 07 AND; 08 OR; 09 XOR; 0A NAND.
  - 0B LSL A; 0C LSR A; 0D ASR A.
  - 0E rotate left through carry: {A[W-2:0],C0}.
  - 0F rotate right through carry: {C0,A[W-1:1]}.
  - 10 MULU; 11 DIVU.
  - 12-1F: illegal. Single-cycle; ALUOut=0, ALUOutHi=0, flags unchanged regardless of WF.
- MULU: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product split into {ALUOutHi, ALUOut}.
- DIVU: restoring division, one quotient bit per cycle.
  - B==0: no RUN. Go directly to FIN with ALUOut = all ones, ALUOutHi = A, DivByZero=1.
- Flags update only if the latched WF=1. Unlisted flags are unchanged.
  - Z = (ALUOut==0) for all ops. For MULU, Z = full product == 0.
  - N = ALUOut[W-1] for all legal ops.
  - C, ADD/ADDC: carry-out of the W-bit sum.
  - C, SUB: 1 iff A>=B unsigned (no borrow).
  - C, LSL/rotate-left: A[W-1]. C, LSR/ASR/rotate-right: A[0].
  - C and O, MULU: both = (ALUOutHi != 0).
  - O, ADD/ADDC: same-sign operands give a different-sign result.
  - O, SUB: A and B differ in sign and the result differs in sign from A.
  - O, DIVU: O = DivByZero; C unchanged.
  - Logic ops and pass ops: C and O unchanged.
- Operand inputs may change freely after the accept cycle.

Test Plan:
- WIDTH=8, WF=1: Start Op=04 A=0x7F B=0x01 -> Done one cycle later; ALUOut=0x80; flags Z=0 C=0 N=1 O=1.
- WIDTH=8, Op=06 A=0x05 B=0x05 -> ALUOut=0x00, Z=1 C=1 N=0 O=0. Then WF=0, Op=07 A=0xF0 B=0x0F -> ALUOut=0, flags unchanged at 4'b1100.
- WIDTH=32, Op=10 A=0xFFFFFFFF B=0x00000002:
  - Busy high for 32 cycles; Done at cycle 33.
  - ALUOutHi=0x00000001, ALUOut=0xFFFFFFFE; C=1, O=1.
  - Start pulsed mid-RUN is ignored.
- WIDTH=8, Op=11 A=200 B=7 -> ALUOut=28, ALUOutHi=4, DivByZero=0 at cycle 9. Then Op=11 B=0 -> Done next cycle; ALUOut=0xFF, ALUOutHi=200, DivByZero=1, O=1.
- WIDTH=8, C=1, Op=0E A=0x80 -> ALUOut=0x01, C=1. Then Op=0F A=0x01 with C=1 -> ALUOut=0x80, C=1.
- WIDTH=8, Reset asserted at cycle 4 of a MULU run -> no Done; all outputs and flags 0 on the next cycle; state IDLE. Then Op=1F -> Done next cycle, ALUOut=0, flags unchanged.

Source files
------------

// File: rtl/iterative_alu_if.sv
// Request/response bundle between the control unit and iterative_alu.
// Start/Done handshake: Start is a one-shot request taken only while Busy is low
// (IDLE or FIN); Done strobes for one cycle when results and flags are valid.
interface iterative_alu_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [4:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             WF;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] ALUOut;
    logic [WIDTH-1:0] ALUOutHi;
    logic [3:0]       FlagsOut;
    logic             DivByZero;
    logic [1:0]       dbg_state;

    modport master (
        output Start, Op, A, B, WF,
        input  Busy, Done, ALUOut, ALUOutHi, FlagsOut, DivByZero, dbg_state
    );

    modport slave (
        input  Start, Op, A, B, WF,
        output Busy, Done, ALUOut, ALUOutHi, FlagsOut, DivByZero, dbg_state
    );
endinterface

// File: rtl/iterative_alu.sv
// Parametrised ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide, one bit per cycle.
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic            Clock,
    input logic            Reset,
    iterative_alu_if.slave bus
);
    localparam logic [4:0] OP_PASS_A = 5'h00, OP_PASS_B = 5'h01, OP_NOT_A = 5'h02;
    localparam logic [4:0] OP_NOT_B  = 5'h03, OP_ADD    = 5'h04, OP_ADDC  = 5'h05;
    localparam logic [4:0] OP_SUB    = 5'h06, OP_AND    = 5'h07, OP_OR    = 5'h08;
    localparam logic [4:0] OP_XOR    = 5'h09, OP_NAND   = 5'h0A, OP_LSL   = 5'h0B;
    localparam logic [4:0] OP_LSR    = 5'h0C, OP_ASR    = 5'h0D, OP_ROL   = 5'h0E;
    localparam logic [4:0] OP_ROR    = 5'h0F, OP_MULU   = 5'h10, OP_DIVU  = 5'h11;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       op_q;
    logic             wf_q;
    logic [WIDTH-1:0] a_q, b_q, work_hi, work_lo;
    logic [WIDTH-1:0] res_lo, res_hi;
    logic [3:0]       flags;
    logic             dbz;

    logic accept, multi;
    assign accept = bus.Start && (state != S_RUN);
    assign multi  = (bus.Op == OP_MULU) || ((bus.Op == OP_DIVU) && (bus.B != '0));

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (bus.Start) state_n = multi ? S_RUN : S_FIN;
            S_FIN:   state_n = bus.Start ? (multi ? S_RUN : S_FIN) : S_IDLE;
            S_RUN:   if (cnt == LAST_STEP) state_n = S_FIN;
            default: state_n = S_IDLE;
        endcase
    end

    // Single-cycle results are computed straight from the bus and committed on the accept edge.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff, sc_lo, sc_hi;
    logic             sc_c, sc_o, sc_legal, sc_dbz;
    logic [3:0]       sc_flags;

    always_comb begin
        sum      = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, (bus.Op == OP_ADDC) & flags[2]};
        diff     = bus.A - bus.B;
        sc_lo    = '0;
        sc_hi    = '0;
        sc_c     = flags[2];
        sc_o     = flags[0];
        sc_legal = 1'b1;
        sc_dbz   = 1'b0;
        case (bus.Op)
            OP_PASS_A: sc_lo = bus.A;
            OP_PASS_B: sc_lo = bus.B;
            OP_NOT_A:  sc_lo = ~bus.A;
            OP_NOT_B:  sc_lo = ~bus.B;
            OP_ADD, OP_ADDC: begin
                sc_lo = sum[WIDTH-1:0];
                sc_c  = sum[WIDTH];
                sc_o  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo = diff;
                sc_c  = (bus.A >= bus.B);
                sc_o  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  sc_lo = bus.A & bus.B;
            OP_OR:   sc_lo = bus.A | bus.B;
            OP_XOR:  sc_lo = bus.A ^ bus.B;
            OP_NAND: sc_lo = ~(bus.A & bus.B);
            OP_LSL: begin sc_lo = {bus.A[WIDTH-2:0], 1'b0};             sc_c = bus.A[WIDTH-1]; end
            OP_LSR: begin sc_lo = {1'b0, bus.A[WIDTH-1:1]};             sc_c = bus.A[0];       end
            OP_ASR: begin sc_lo = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};   sc_c = bus.A[0];       end
            OP_ROL: begin sc_lo = {bus.A[WIDTH-2:0], flags[2]};         sc_c = bus.A[WIDTH-1]; end
            OP_ROR: begin sc_lo = {flags[2], bus.A[WIDTH-1:1]};         sc_c = bus.A[0];       end
            OP_DIVU: begin
                sc_lo  = '1;
                sc_hi  = bus.A;
                sc_dbz = 1'b1;
                sc_o   = 1'b1;
            end
            default: sc_legal = 1'b0;
        endcase
        sc_flags = (bus.WF && sc_legal) ? {sc_lo == '0, sc_c, sc_lo[WIDTH-1], sc_o} : flags;
    end

    // One iteration: multiply shifts the partial product right, divide shifts the remainder left.
    logic [WIDTH:0]   mul_sum, div_sh;
    logic [WIDTH-1:0] div_rem, step_hi, step_lo;
    logic             div_ge, is_mul, hi_nz;
    logic [3:0]       fin_flags;
    assign is_mul = (op_q == OP_MULU);

    always_comb begin
        mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : '0);
        div_sh  = {work_hi, work_lo[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, b_q});
        div_rem = div_sh[WIDTH-1:0] - b_q;
        if (is_mul) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_ge ? div_rem : div_sh[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], div_ge};
        end
        hi_nz     = (step_hi != '0);
        fin_flags = flags;
        if (wf_q) begin
            fin_flags = {(step_lo == '0) && !(is_mul && hi_nz), is_mul ? hi_nz : flags[2],
                         step_lo[WIDTH-1], is_mul && hi_nz};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= '0;
            wf_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            res_lo  <= '0;
            res_hi  <= '0;
            flags   <= '0;
            dbz     <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q    <= bus.Op;
                wf_q    <= bus.WF;
                a_q     <= bus.A;
                b_q     <= bus.B;
                cnt     <= '0;
                work_hi <= '0;
                work_lo <= (bus.Op == OP_MULU) ? bus.B : bus.A;
                dbz     <= sc_dbz && !multi;
                if (!multi) begin
                    res_lo <= sc_lo;
                    res_hi <= sc_hi;
                    flags  <= sc_flags;
                end
            end else if (state == S_RUN) begin
                cnt     <= cnt + 1'b1;
                work_hi <= step_hi;
                work_lo <= step_lo;
                if (cnt == LAST_STEP) begin
                    res_lo <= step_lo;
                    res_hi <= step_hi;
                    flags  <= fin_flags;
                end
            end
        end
    end

    assign bus.Busy      = (state == S_RUN);
    assign bus.Done      = (state == S_FIN);
    assign bus.ALUOut    = res_lo;
    assign bus.ALUOutHi  = res_hi;
    assign bus.FlagsOut  = flags;
    assign bus.DivByZero = dbz;
    assign bus.dbg_state = state;
endmodule
